pipeline_control_unit: RTL
==========================

Name: pipeline_control_unit

Overview:
Central stall/flush/run sequencer for the 5-stage MIPS pipeline, next to the forwarding unit. Detects load-use hazards the forwarding paths cannot cover, issues branch flushes, and gates the whole pipeline under debug-unit control (run, single-step, halt on HALT instruction). Drives PC write, IF/ID write, IF/ID and ID/EX flush, and the global pipeline enable.

Parameters:
REG_ADDR_W, 5, register-address width
STEP_CYCLES, 1, clock cycles of pipeline enable per debug step (1..255)
CNT_W, 32, width of stall counter (optional feature)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_run  in  1  debug: start continuous execution (1-cycle pulse)
i_step  in  1  debug: execute one step (1-cycle pulse)
i_clear  in  1  debug: return to IDLE from any state (1-cycle pulse)
i_halt_wb  in  1  HALT instruction reached MEM/WB
i_mem_read_idex  in  1  ID/EX instruction is a load
i_rt_idex  in  REG_ADDR_W  load destination in ID/EX
i_rs_ifid  in  REG_ADDR_W  source 1 of IF/ID instruction
i_rt_ifid  in  REG_ADDR_W  source 2 of IF/ID instruction
i_branch_taken  in  1  branch/jump resolved taken this cycle
o_pipe_en  out  1  global pipeline-register enable
o_pc_write  out  1  PC update enable
o_ifid_write  out  1  IF/ID write enable
o_ifid_flush  out  1  zero IF/ID
o_idex_flush  out  1  insert bubble into ID/EX
o_halted  out  1  processor halted (registered)
o_step_done  out  1  step complete (1-cycle registered pulse)
o_stall_count  out  CNT_W  stall/flush cycle count (optional feature)

Behaviour:
- Reset: state IDLE, step counter 0; all outputs 0. Reset mid-step aborts the step, no o_step_done.
- States: IDLE, RUN, STEP, HALT. Transitions registered on rising i_clk.
- IDLE: o_pipe_en=0. i_run -> RUN; else i_step -> STEP (load counter STEP_CYCLES). i_run and i_step together: RUN wins.
- RUN: o_pipe_en=1 until i_halt_wb -> HALT. i_run/i_step ignored.
- STEP: o_pipe_en=1 for exactly STEP_CYCLES cycles; on last cycle go IDLE and pulse o_step_done the following cycle. i_halt_wb during STEP -> HALT; o_step_done still pulses once.
- HALT: o_pipe_en=0, o_halted=1 from the cycle after entry. i_run/i_step ignored.
- i_clear in any state -> IDLE next cycle; highest priority after reset; clears o_halted.
- Hazard outputs combinational, zero latency, all forced 0 when o_pipe_en=0 except o_pc_write/o_ifid_write which also drop to 0.
- load_use = i_mem_read_idex & (i_rt_idex!=0) & (i_rt_idex==i_rs_ifid | i_rt_idex==i_rt_ifid).
- Branch: i_branch_taken -> o_ifid_flush=1, o_idex_flush=1, o_pc_write=1, o_ifid_write=1. Takes priority over load_use (stalled instruction is discarded).
- Load-use (no branch): o_pc_write=0, o_ifid_write=0, o_idex_flush=1 for one cycle. A registered stall_q blocks re-triggering the next cycle (max 1 bubble per load).
- Otherwise with o_pipe_en=1: o_pc_write=o_ifid_write=1, flushes 0.

Optional Feature:
STALL_COUNTER_EN: defined -> o_stall_count increments each enabled cycle with load-use stall or branch flush; saturates at all-ones; reset and i_clear zero it. Undefined -> no counter logic, o_stall_count tied to 0.

Decomposition:
- Shared package mips_pkg: state enum (IDLE/RUN/STEP/HALT), REG_ADDR_W constant, control-bit encodings.
- One sub-module: hazard_detect (combinational load_use comparator, instantiated once).

Test Plan:
- Reset low mid-RUN -> all outputs 0, state IDLE; release, i_run pulse -> o_pipe_en=1 next cycle.
- RUN, i_mem_read_idex=1, i_rt_idex=8, i_rs_ifid=8 -> one cycle o_pc_write=0, o_ifid_write=0, o_idex_flush=1; next cycle normal despite unchanged inputs.
- Same load with i_rt_idex=0 -> no stall; load-use plus i_branch_taken -> o_ifid_flush=1, o_idex_flush=1, o_pc_write=1.
- IDLE, STEP_CYCLES=1, i_step -> o_pipe_en=1 exactly 1 cycle, o_step_done pulse 1 cycle later, back to IDLE; i_run+i_step together -> RUN.
- RUN, i_halt_wb=1 -> o_pipe_en=0, o_halted=1; i_run ignored; i_clear -> IDLE, o_halted=0.
- STALL_COUNTER_EN defined: 3 load-use stalls + 2 branch flushes -> o_stall_count=5; i_clear -> 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline control logic:
// sequencer states, register-address width and hazard control encodings.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int STEP_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    HALT = 2'd3
  } state_t;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_OFF    = 4'b0000;
  localparam ctrl_t CTRL_NORMAL = 4'b1100;
  localparam ctrl_t CTRL_STALL  = 4'b0001;
  localparam ctrl_t CTRL_FLUSH  = 4'b1111;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: the ID/EX load writes a register the IF/ID
// instruction reads, which forwarding cannot cover in time.
module hazard_detect #(
  parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W
) (
  input  logic                  mem_read_idex,
  input  logic [REG_ADDR_W-1:0] rt_idex,
  input  logic [REG_ADDR_W-1:0] rs_ifid,
  input  logic [REG_ADDR_W-1:0] rt_ifid,
  output logic                  load_use
);

  // $zero is never a real dependency
  assign load_use = mem_read_idex && (rt_idex != '0) &&
                    ((rt_idex == rs_ifid) || (rt_idex == rt_ifid));

endmodule

// File: rtl/pipeline_control_unit.sv
// Stall/flush/run sequencer for the 5-stage pipeline with debug run/step/halt.
// Optional stall counter enabled by defining STALL_COUNTER_EN.
module pipeline_control_unit #(
  parameter int REG_ADDR_W  = mips_pkg::REG_ADDR_W,
  parameter int STEP_CYCLES = 1,
  parameter int CNT_W       = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_run,
  input  logic                  i_step,
  input  logic                  i_clear,
  input  logic                  i_halt_wb,
  input  logic                  i_mem_read_idex,
  input  logic [REG_ADDR_W-1:0] i_rt_idex,
  input  logic [REG_ADDR_W-1:0] i_rs_ifid,
  input  logic [REG_ADDR_W-1:0] i_rt_ifid,
  input  logic                  i_branch_taken,
  output logic                  o_pipe_en,
  output logic                  o_pc_write,
  output logic                  o_ifid_write,
  output logic                  o_ifid_flush,
  output logic                  o_idex_flush,
  output logic                  o_halted,
  output logic                  o_step_done,
  output logic [CNT_W-1:0]      o_stall_count
);

  import mips_pkg::*;

  state_t                state_q, state_d;
  logic [STEP_CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic                  step_done_d, step_done_q;
  logic                  halted_q;
  logic                  stall_q;
  logic                  load_use;
  logic                  stall_fire;
  ctrl_t                 ctrl;

  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_detect (
    .mem_read_idex (i_mem_read_idex),
    .rt_idex       (i_rt_idex),
    .rs_ifid       (i_rs_ifid),
    .rt_ifid       (i_rt_ifid),
    .load_use      (load_use)
  );

  assign o_pipe_en  = (state_q == RUN) || (state_q == STEP);
  // stall_q limits each load to a single bubble even if inputs stay unchanged
  assign stall_fire = o_pipe_en && load_use && !i_branch_taken && !stall_q;

  always_comb begin
    state_d     = state_q;
    step_cnt_d  = step_cnt_q;
    step_done_d = 1'b0;
    if (i_clear) begin
      state_d    = IDLE;
      step_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_run) begin
            state_d = RUN;
          end else if (i_step) begin
            state_d    = STEP;
            step_cnt_d = STEP_CNT_W'(STEP_CYCLES);
          end
        end
        RUN: begin
          if (i_halt_wb) state_d = HALT;
        end
        STEP: begin
          if (i_halt_wb) begin
            state_d     = HALT;
            step_cnt_d  = '0;
            step_done_d = 1'b1;
          end else if (step_cnt_q <= STEP_CNT_W'(1)) begin
            state_d     = IDLE;
            step_cnt_d  = '0;
            step_done_d = 1'b1;
          end else begin
            step_cnt_d = step_cnt_q - STEP_CNT_W'(1);
          end
        end
        HALT: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      step_cnt_q  <= '0;
      step_done_q <= 1'b0;
      halted_q    <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_cnt_q  <= step_cnt_d;
      step_done_q <= step_done_d;
      halted_q    <= (state_d == HALT);
      stall_q     <= stall_fire;
    end
  end

  // a taken branch discards the stalled instruction, so it outranks load-use
  always_comb begin
    ctrl = CTRL_OFF;
    if (o_pipe_en) begin
      if (i_branch_taken)  ctrl = CTRL_FLUSH;
      else if (stall_fire) ctrl = CTRL_STALL;
      else                 ctrl = CTRL_NORMAL;
    end
  end

  assign o_pc_write   = ctrl.pc_write;
  assign o_ifid_write = ctrl.ifid_write;
  assign o_ifid_flush = ctrl.ifid_flush;
  assign o_idex_flush = ctrl.idex_flush;
  assign o_halted     = halted_q;
  assign o_step_done  = step_done_q;

`ifdef STALL_COUNTER_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
    end else if (i_clear) begin
      stall_cnt_q <= '0;
    end else if (o_pipe_en && (stall_fire || i_branch_taken) && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign o_stall_count = stall_cnt_q;
`else
  assign o_stall_count = '0;
`endif

endmodule
